vga_timing_checker: RTL and testbench
=====================================

Name: vga_timing_checker

Overview:
- Downstream monitor for the PanelDisplay VGA stage. Consumes pxlClk, hsync, vsync and the 4-bit red/green/blue outputs.
- Measures line and frame timing against the 800x600@72 Hz (SVGA) standard and checks that colour is zero during blanking.
- Reports lock status, sticky error flags and a good-frame counter.
- Used in system checks and in the display testbench as a self-checking scoreboard instead of file-based inspection.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 56, horizontal front porch (pixels)
H_SYNC, 120, hsync pulse width (pixels)
H_BP, 64, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines per frame
V_FP, 37, vertical front porch (lines)
V_SYNC, 6, vsync pulse width (lines)
V_BP, 23, vertical back porch (lines)
SYNC_POL, 1, sync active level (1 = active-high, 0 = active-low)

Ports:
clk  in  1  system clock (100 MHz); pxlClk = clk/2
rst  in  1  synchronous, active-low reset
pxlClk  in  1  pixel clock from PanelDisplay, treated as data (not a clock)
hsync  in  1  horizontal sync
vsync  in  1  vertical sync
red  in  4  pixel red
green  in  4  pixel green
blue  in  4  pixel blue
clr_err  in  1  one-cycle pulse that clears sticky errors
locked  out  1  timing matches parameters
err_hsync  out  1  sticky: bad line length or bad hsync width
err_vsync  out  1  sticky: bad frame length or bad vsync width
err_blank  out  1  sticky: non-zero colour in blanking
frame_cnt  out  16  good frames counted while locked; wraps at 65535
line_len  out  11  last measured pixels per line
frame_lines  out  11  last measured lines per frame

Behaviour:
- Reset (rst=0 at posedge clk): all outputs and internal counters go to 0; state goes to WAIT_VS.
- Pixel strobe: pclk_d <= pxlClk; pxl_en = pxlClk & ~pclk_d. All sampling occurs only in cycles where pxl_en=1.
- Sample pipeline: hsync, vsync and the colour inputs are registered on pxl_en.
  - Sync levels are normalised with SYNC_POL, so the active level becomes 1.
  - Leading edge = sample 1 and previous sample 0.
  - Trailing edge = sample 0 and previous sample 1.
- hpos (11 bit, saturates at 2047): set to 0 on the hsync leading edge, otherwise +1 per pxl_en.
- hs_w: counts sampled pixels while hsync is active.
- vline (11 bit, saturating): set to 0 on the vsync leading edge, otherwise +1 per hsync leading edge. Counts the line containing the edge.
- vs_w: counts hsync leading edges while vsync is active.
- h_seen: set on the first hsync leading edge after reset. No line-length check is made before h_seen=1.
- Checks: a mismatch raises a per-frame bad flag and the matching sticky error.
  - At each hsync leading edge: line_len <= hpos+1; mismatch if it is not H_TOTAL = 1040.
  - At each hsync trailing edge: mismatch if hs_w is not H_SYNC.
  - At each vsync leading edge: frame_lines <= vline+1; mismatch if it is not V_TOTAL = 666.
  - At each vsync trailing edge: mismatch if vs_w is not V_SYNC.
  - Blank check: any sampled colour bit is 1 while hpos is outside [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] or vline is outside [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1]. This sets err_blank only and does not affect lock.
- FSM:
  - WAIT_VS: no checks, no errors. On vsync leading edge, clear the bad flag and go to MEASURE.
  - MEASURE: on vsync leading edge, if the bad flag is clear go to LOCKED, otherwise clear it and stay in MEASURE.
  - LOCKED: locked=1, registered, so valid one clk after entry.
    - Any h/v mismatch: go to MEASURE next clk and set locked=0.
    - On vsync leading edge with no mismatch in the frame: frame_cnt+1.
- Simultaneous events:
  - hsync and vsync leading edges on the same sample: the line check is applied, then vline resets.
  - clr_err together with a new error: the error wins and the flag stays 1.
  - clr_err does not affect locked or frame_cnt.
- Reset mid-frame: immediate return to WAIT_VS. Errors are not reported for the partial frame.
- Checks run in all states; sticky errors are set in MEASURE and LOCKED only.

Decomposition:
- Package vga_timing_pkg holds:
  - the SVGA default timing constants (H_* and V_*, H_TOTAL, V_TOTAL);
  - typedef enum logic [1:0] {WAIT_VS, MEASURE, LOCKED} chk_state_t;
  - typedef logic [10:0] vga_cnt_t, shared with PanelDisplay hcount/vcount.
- Sub-module sync_meter: edge detect plus a period counter and a pulse-width counter, taking an enable. It is instantiated twice:
  - horizontal: enable = pxl_en;
  - vertical: enable = hsync leading edge.

Test Plan:
- Nominal PanelDisplay-timed model, 3 frames -> locked=1 one clk after the 2nd vsync leading edge; frame_cnt=1 after the 3rd; all errors 0; line_len=1040; frame_lines=666.
- While locked, one line of 1039 pixels -> err_hsync=1, locked=0 within 2 clk; relock after the next clean frame; line_len=1039 then 1040.
- vsync pulse of 5 lines -> err_vsync=1 at the vsync trailing edge and locked drops; a clean frame then relocks.
- red=4'hF at hpos=1000 (front porch) -> err_blank=1, locked stays 1; clr_err clears it; clr_err pulsed on the same cycle as a second blank violation -> err_blank stays 1.
- rst=0 for 1 clk mid-frame while locked -> next clk all outputs 0 and state WAIT_VS; locked returns after 2 vsync leading edges.
- SYNC_POL=0 with inverted syncs -> same results as the nominal case.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// vga_timing_pkg : SVGA 800x600@72 timing constants and shared checker types
// Revision 1.0
// ============================================================================
package vga_timing_pkg;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 56;
  localparam int H_SYNC   = 120;
  localparam int H_BP     = 64;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 37;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 23;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } chk_state_t;

  // Same width as the PanelDisplay hcount/vcount registers.
  typedef logic [10:0] vga_cnt_t;

  localparam vga_cnt_t CNT_MAX = '1;

  function automatic vga_cnt_t sat_inc(input vga_cnt_t v);
    return (v == CNT_MAX) ? v : v + vga_cnt_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_meter.sv
`default_nettype none
// ============================================================================
// sync_meter : edge detector with saturating period and pulse-width counters
// Revision 1.0
// ============================================================================
module sync_meter
  import vga_timing_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  logic     level,
  output logic     lead,
  output logic     trail,
  output vga_cnt_t count,
  output vga_cnt_t count_cur,
  output vga_cnt_t width
);

  logic prev;

  assign lead  = en & level & ~prev;
  assign trail = en & ~level & prev;

  // Position of the sample being evaluated right now (register is one behind).
  always_comb begin
    count_cur = count;
    if (en) begin
      count_cur = lead ? '0 : sat_inc(count);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev  <= 1'b0;
      count <= '0;
      width <= '0;
    end else if (en) begin
      prev  <= level;
      count <= count_cur;
      if (level) begin
        width <= prev ? sat_inc(width) : vga_cnt_t'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_checker.sv
`default_nettype none
// ============================================================================
// vga_timing_checker : VGA line/frame timing, sync width and blanking monitor
// Revision 1.0
// ============================================================================
module vga_timing_checker #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxlClk,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  input  logic        clr_err,
  output logic        locked,
  output logic        err_hsync,
  output logic        err_vsync,
  output logic        err_blank,
  output logic [15:0] frame_cnt,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines
);

  import vga_timing_pkg::*;

  localparam vga_cnt_t H_TOT  = vga_cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam vga_cnt_t V_TOT  = vga_cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam vga_cnt_t H_SW   = vga_cnt_t'(H_SYNC);
  localparam vga_cnt_t V_SW   = vga_cnt_t'(V_SYNC);
  localparam vga_cnt_t HA_LO  = vga_cnt_t'(H_SYNC + H_BP);
  localparam vga_cnt_t HA_HI  = vga_cnt_t'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam vga_cnt_t VA_LO  = vga_cnt_t'(V_SYNC + V_BP);
  localparam vga_cnt_t VA_HI  = vga_cnt_t'(V_SYNC + V_BP + V_ACTIVE - 1);

  chk_state_t  state, state_nx;
  logic        bad, bad_nx;
  logic        pclk_d, pxl_en, smp_en;
  logic        hs_s, vs_s;
  logic [11:0] rgb_s;
  logic        h_seen;
  logic        h_lead, h_trail, v_lead, v_trail;
  vga_cnt_t    hpos, hpos_cur, hs_w, vline, vline_cur, vs_w;
  vga_cnt_t    h_len, v_len;
  logic        h_mis, v_mis, frame_bad, in_active, blank_bad, chk_on;
  logic        locked_nx, err_hsync_nx, err_vsync_nx, err_blank_nx;
  logic [15:0] frame_cnt_nx;

  assign pxl_en = pxlClk & ~pclk_d;

  // Syncs are stored normalised so that 1 always means "pulse active".
  always_ff @(posedge clk) begin
    if (!rst) begin
      pclk_d <= 1'b0;
      smp_en <= 1'b0;
      hs_s   <= 1'b0;
      vs_s   <= 1'b0;
      rgb_s  <= '0;
    end else begin
      pclk_d <= pxlClk;
      smp_en <= pxl_en;
      if (pxl_en) begin
        hs_s  <= (hsync == SYNC_POL);
        vs_s  <= (vsync == SYNC_POL);
        rgb_s <= {red, green, blue};
      end
    end
  end

  sync_meter u_hmeter (
    .clk       (clk),
    .rst       (rst),
    .en        (smp_en),
    .level     (hs_s),
    .lead      (h_lead),
    .trail     (h_trail),
    .count     (hpos),
    .count_cur (hpos_cur),
    .width     (hs_w)
  );

  sync_meter u_vmeter (
    .clk       (clk),
    .rst       (rst),
    .en        (h_lead),
    .level     (vs_s),
    .lead      (v_lead),
    .trail     (v_trail),
    .count     (vline),
    .count_cur (vline_cur),
    .width     (vs_w)
  );

  assign h_len     = sat_inc(hpos);
  assign v_len     = sat_inc(vline);
  assign h_mis     = h_seen & ((h_lead & (h_len != H_TOT)) | (h_trail & (hs_w != H_SW)));
  assign v_mis     = (v_lead & (v_len != V_TOT)) | (v_trail & (vs_w != V_SW));
  assign frame_bad = bad | h_mis | v_mis;
  assign in_active = (hpos_cur >= HA_LO) && (hpos_cur <= HA_HI) &&
                     (vline_cur >= VA_LO) && (vline_cur <= VA_HI);
  assign blank_bad = smp_en & (|rgb_s) & ~in_active;
  assign chk_on    = (state != WAIT_VS);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= WAIT_VS;
      bad         <= 1'b0;
      h_seen      <= 1'b0;
      locked      <= 1'b0;
      err_hsync   <= 1'b0;
      err_vsync   <= 1'b0;
      err_blank   <= 1'b0;
      frame_cnt   <= '0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      state     <= state_nx;
      bad       <= bad_nx;
      locked    <= locked_nx;
      err_hsync <= err_hsync_nx;
      err_vsync <= err_vsync_nx;
      err_blank <= err_blank_nx;
      frame_cnt <= frame_cnt_nx;
      if (h_lead) begin
        h_seen   <= 1'b1;
        line_len <= h_len;
      end
      if (v_lead) begin
        frame_lines <= v_len;
      end
    end
  end

  always_comb begin
    state_nx = state;
    bad_nx   = bad;
    case (state)
      WAIT_VS: begin
        if (v_lead) begin
          state_nx = MEASURE;
          bad_nx   = 1'b0;
        end
      end
      MEASURE: begin
        if (v_lead) begin
          bad_nx = 1'b0;
          if (!frame_bad) state_nx = LOCKED;
        end else begin
          bad_nx = frame_bad;
        end
      end
      LOCKED: begin
        // A mismatch on the frame boundary closes the bad frame, so the next one starts clean.
        if (h_mis | v_mis) begin
          state_nx = MEASURE;
          bad_nx   = ~v_lead;
        end
      end
      default: begin
        state_nx = WAIT_VS;
        bad_nx   = 1'b0;
      end
    endcase
  end

  always_comb begin
    locked_nx    = (state == LOCKED);
    frame_cnt_nx = frame_cnt;
    if ((state == LOCKED) && v_lead && !frame_bad) begin
      frame_cnt_nx = frame_cnt + 16'd1;
    end
    err_hsync_nx = (err_hsync & ~clr_err) | (chk_on & h_mis);
    err_vsync_nx = (err_vsync & ~clr_err) | (chk_on & v_mis);
    err_blank_nx = (err_blank & ~clr_err) | (chk_on & blank_bad);
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_checker.sv
`default_nettype none
// ============================================================================
// tb_vga_timing_checker : directed bench on a reduced timing (15 x 9 frame)
// Revision 1.0
// ============================================================================
module tb_vga_timing_checker;

  import vga_timing_pkg::*;

  localparam int TH_ACTIVE = 8;
  localparam int TH_FP     = 2;
  localparam int TH_SYNC   = 3;
  localparam int TH_BP     = 2;
  localparam int TV_ACTIVE = 4;
  localparam int TV_FP     = 2;
  localparam int TV_SYNC   = 2;
  localparam int TV_BP     = 1;
  localparam int TH_TOTAL  = TH_ACTIVE + TH_FP + TH_SYNC + TH_BP;  // 15
  localparam int TV_TOTAL  = TV_ACTIVE + TV_FP + TV_SYNC + TV_BP;  // 9

  logic        clk = 1'b0;
  logic        rst, pxlClk, hsync, vsync, hsync_n, vsync_n, clr_err;
  logic [3:0]  red, green, blue;
  logic        locked, err_hsync, err_vsync, err_blank;
  logic [15:0] frame_cnt;
  logic [10:0] line_len, frame_lines;
  logic        locked_n, err_hsync_n, err_vsync_n, err_blank_n;
  logic [15:0] frame_cnt_n;
  logic [10:0] line_len_n, frame_lines_n;

  int n_tests = 0;
  int n_fail  = 0;
  int inj_line = -1, inj_px = -1, clr_line = -1, clr_px = -1;

  always #5 clk = ~clk;

  vga_timing_checker #(
    .H_ACTIVE(TH_ACTIVE), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_BP(TH_BP),
    .V_ACTIVE(TV_ACTIVE), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
    .SYNC_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .pxlClk(pxlClk), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .clr_err(clr_err),
    .locked(locked), .err_hsync(err_hsync), .err_vsync(err_vsync), .err_blank(err_blank),
    .frame_cnt(frame_cnt), .line_len(line_len), .frame_lines(frame_lines)
  );

  vga_timing_checker #(
    .H_ACTIVE(TH_ACTIVE), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_BP(TH_BP),
    .V_ACTIVE(TV_ACTIVE), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
    .SYNC_POL(1'b0)
  ) dut_n (
    .clk(clk), .rst(rst), .pxlClk(pxlClk), .hsync(hsync_n), .vsync(vsync_n),
    .red(red), .green(green), .blue(blue), .clr_err(clr_err),
    .locked(locked_n), .err_hsync(err_hsync_n), .err_vsync(err_vsync_n), .err_blank(err_blank_n),
    .frame_cnt(frame_cnt_n), .line_len(line_len_n), .frame_lines(frame_lines_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel = two clk cycles; clr_err is held for exactly the cycle the sample is evaluated.
  task automatic pixel(input logic hs, input logic vs, input logic [3:0] r, input logic [3:0] g,
                       input logic [3:0] b, input logic clr);
    @(negedge clk);
    pxlClk = 1'b1; hsync = hs; vsync = vs; hsync_n = ~hs; vsync_n = ~vs;
    red = r; green = g; blue = b; clr_err = 1'b0;
    @(negedge clk);
    pxlClk = 1'b0; clr_err = clr;
  endtask

  task automatic settle();
    @(negedge clk);
    clr_err = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_pixels(input int l, input int vs_lines, input int p0, input int p1);
    logic       act;
    logic [3:0] r, g, b;
    for (int p = p0; p <= p1; p++) begin
      act = (p >= TH_SYNC + TH_BP) && (p <= TH_SYNC + TH_BP + TH_ACTIVE - 1) &&
            (l >= TV_SYNC + TV_BP) && (l <= TV_SYNC + TV_BP + TV_ACTIVE - 1);
      r = act ? 4'(l + 1) : 4'h0;
      g = act ? 4'h5 : 4'h0;
      b = act ? 4'(p) : 4'h0;
      if (l == inj_line && p == inj_px) r = 4'hF;
      pixel(p < TH_SYNC, l < vs_lines, r, g, b, (l == clr_line && p == clr_px));
    end
  endtask

  task automatic do_line(input int l, input int len, input int vs_lines);
    do_pixels(l, vs_lines, 0, len - 1);
  endtask

  task automatic do_frame(input int vs_lines);
    for (int l = 0; l < TV_TOTAL; l++) do_line(l, TH_TOTAL, vs_lines);
  endtask

  initial begin
    rst = 1'b0; pxlClk = 1'b0; hsync = 1'b0; vsync = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1;
    red = 4'h0; green = 4'h0; blue = 4'h0; clr_err = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_errs", {err_hsync, err_vsync, err_blank}, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_lens", {line_len, frame_lines}, 0);
    chk("rst_state", dut.state, WAIT_VS);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) pixel(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);

    // Nominal: lock at the 2nd vsync edge, first good frame counted at the 3rd.
    do_frame(TV_SYNC); settle();
    chk("f1_locked", locked, 0);
    chk("f1_state", dut.state, MEASURE);
    do_frame(TV_SYNC); settle();
    chk("f2_locked", locked, 1);
    chk("f2_frame_cnt", frame_cnt, 0);
    do_frame(TV_SYNC); settle();
    chk("f3_frame_cnt", frame_cnt, 1);
    chk("f3_line_len", line_len, TH_TOTAL);
    chk("f3_frame_lines", frame_lines, TV_TOTAL);
    chk("f3_errs", {err_hsync, err_vsync, err_blank}, 0);
    chk("pol0_locked", locked_n, 1);
    chk("pol0_frame_cnt", frame_cnt_n, 1);
    chk("pol0_lens", {line_len_n, frame_lines_n}, {11'(TH_TOTAL), 11'(TV_TOTAL)});
    chk("pol0_errs", {err_hsync_n, err_vsync_n, err_blank_n}, 0);

    // Short line (one pixel missing) while locked.
    for (int l = 0; l < 4; l++) do_line(l, TH_TOTAL, TV_SYNC);
    do_line(4, TH_TOTAL - 1, TV_SYNC);
    do_line(5, TH_TOTAL, TV_SYNC); settle();
    chk("short_line_len", line_len, TH_TOTAL - 1);
    chk("short_err_hsync", err_hsync, 1);
    chk("short_locked", locked, 0);
    do_line(6, TH_TOTAL, TV_SYNC); settle();
    chk("short_line_len_back", line_len, TH_TOTAL);
    for (int l = 7; l < TV_TOTAL; l++) do_line(l, TH_TOTAL, TV_SYNC);
    do_frame(TV_SYNC); settle();
    chk("short_still_unlocked", locked, 0);
    do_frame(TV_SYNC); settle();
    chk("short_relock", locked, 1);
    chk("short_frame_cnt", frame_cnt, 2);

    // vsync pulse one line short.
    do_line(0, TH_TOTAL, TV_SYNC - 1);
    do_line(1, TH_TOTAL, TV_SYNC - 1); settle();
    chk("vs_err_vsync", err_vsync, 1);
    chk("vs_locked", locked, 0);
    for (int l = 2; l < TV_TOTAL; l++) do_line(l, TH_TOTAL, TV_SYNC);
    do_frame(TV_SYNC); settle();
    chk("vs_still_unlocked", locked, 0);
    do_frame(TV_SYNC); settle();
    chk("vs_relock", locked, 1);
    chk("vs_frame_cnt", frame_cnt, 3);

    // Blanking violations; clr_err clears, but loses against a simultaneous error.
    clr_line = 0; clr_px = 1;
    do_line(0, TH_TOTAL, TV_SYNC); settle();
    chk("clr_hv_errs", {err_hsync, err_vsync}, 0);
    clr_line = -1;
    for (int l = 1; l < 4; l++) do_line(l, TH_TOTAL, TV_SYNC);
    inj_line = 4; inj_px = TH_SYNC + TH_BP + TH_ACTIVE;
    do_line(4, TH_TOTAL, TV_SYNC); settle();
    chk("blank_fp_err", err_blank, 1);
    chk("blank_fp_locked", locked, 1);
    inj_line = -1; clr_line = 5; clr_px = 1;
    do_line(5, TH_TOTAL, TV_SYNC); settle();
    chk("blank_clr", err_blank, 0);
    clr_line = -1;
    do_line(6, TH_TOTAL, TV_SYNC);
    inj_line = 7; inj_px = 8; clr_line = 7; clr_px = 8;
    do_line(7, TH_TOTAL, TV_SYNC); settle();
    chk("blank_clr_collide", err_blank, 1);
    inj_line = -1; clr_line = -1;
    do_line(8, TH_TOTAL, TV_SYNC);

    clr_line = 0; clr_px = 1;
    do_line(0, TH_TOTAL, TV_SYNC); settle();
    chk("blank_clr2", err_blank, 0);
    chk("blank_frame_cnt", frame_cnt, 5);
    clr_line = -1;
    for (int l = 1; l < 3; l++) do_line(l, TH_TOTAL, TV_SYNC);
    inj_line = 3; inj_px = TH_SYNC + TH_BP - 1;
    do_line(3, TH_TOTAL, TV_SYNC); settle();
    chk("blank_bp_edge", err_blank, 1);
    chk("blank_bp_locked", locked, 1);
    inj_line = -1;

    // One-cycle reset in the middle of a line while locked.
    do_pixels(4, TV_SYNC, 0, 6);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    chk("mrst_locked", locked, 0);
    chk("mrst_errs", {err_hsync, err_vsync, err_blank}, 0);
    chk("mrst_frame_cnt", frame_cnt, 0);
    chk("mrst_lens", {line_len, frame_lines}, 0);
    chk("mrst_state", dut.state, WAIT_VS);
    do_pixels(4, TV_SYNC, 7, TH_TOTAL - 1);
    for (int l = 5; l < TV_TOTAL; l++) do_line(l, TH_TOTAL, TV_SYNC);
    do_frame(TV_SYNC); settle();
    chk("mrst_a_locked", locked, 0);
    chk("mrst_a_errs", {err_hsync, err_vsync, err_blank}, 0);
    do_frame(TV_SYNC); settle();
    chk("mrst_b_locked", locked, 1);
    chk("mrst_b_errs", {err_hsync, err_vsync, err_blank}, 0);
    chk("mrst_b_frame_cnt", frame_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
